// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg -- shared constants, types and helpers for the AER spike encoder.
//
// Contents:
//   AER_CH_W    : width of the channel-ID field of an AER word (4)
//   AER_TS_W    : width of the timestamp field of an AER word (20)
//   AER_WORD_W  : total AER word width (24)
//   aer_word_t  : packed AER word {ch, ts}
//   sat_add16() : 16-bit saturating add, used by the optional drop counter
// ---------------------------------------------------------------------------
package aer_pkg;

  localparam int AER_CH_W   = 4;
  localparam int AER_TS_W   = 20;
  localparam int AER_WORD_W = AER_CH_W + AER_TS_W;

  typedef struct packed {
    logic [AER_CH_W-1:0] ch;
    logic [AER_TS_W-1:0] ts;
  } aer_word_t;

  // Adds b to a and clamps the result at 16'hFFFF.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage : aer_pkg

// File: rtl/aer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aer_rr_arbiter -- purely combinational round-robin picker.
//
// Scans req starting at index ptr (wrapping modulo NUM_CH) and grants the
// first set bit. Nothing is granted while en is low.
//
// Ports:
//   req       in  [NUM_CH-1:0] request vector (pending channels)
//   ptr       in  [IDX_W-1:0]  index where the search starts
//   en        in               grant enable
//   gnt_valid out              a channel was granted
//   gnt_idx   out [IDX_W-1:0]  granted channel (0 when gnt_valid=0)
// ---------------------------------------------------------------------------
module aer_rr_arbiter #(
  parameter int NUM_CH = 16,
  parameter int IDX_W  = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              en,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Offset i walks ptr, ptr+1, ... so the first hit is the fair winner.
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (en && !gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule : aer_rr_arbiter

// File: rtl/aer_encoder.sv
// ---------------------------------------------------------------------------
// aer_encoder -- turns per-channel spike pulses into Address-Event words.
//
// Each spike is latched as a pending bit plus a capture of the free-running
// timestamp. A round-robin arbiter emits one pending channel per cycle as
// {channel, timestamp} unless the downstream FIFO is full.
//
// Output handshake: aer_valid is a one-cycle strobe, one word per high cycle;
// there is no ready. fifo_full is sampled in the grant cycle and acts as a
// stall: while it is high nothing is granted, so the following cycle carries
// no word. data holds its last value whenever aer_valid is low.
//
// Configuration macro:
//   AER_ENC_DROP_CNT_EN : adds drop_count[15:0], a saturating count of
//                         dropped spikes, cleared by rst and overflow_clr.
//
// Ports:
//   clk          in                   clock, rising edge
//   rst          in                   synchronous active-high reset
//   spike_in     in  [NUM_CH-1:0]     spike pulses, one spike per high cycle
//   fifo_full    in                   downstream backpressure
//   overflow_clr in                   clears the sticky overflow flag
//   data         out [AER_CH_W+TS_W-1:0] AER word {channel, timestamp}
//   aer_valid    out                  data carries a new word this cycle
//   overflow     out                  sticky: a spike has been dropped
//   drop_count   out [15:0]           (AER_ENC_DROP_CNT_EN only)
// ---------------------------------------------------------------------------
module aer_encoder
  import aer_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int TS_W   = AER_TS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        spike_in,
  input  logic                     fifo_full,
  input  logic                     overflow_clr,
  output logic [AER_CH_W+TS_W-1:0] data,
  output logic                     aer_valid,
  output logic                     overflow
`ifdef AER_ENC_DROP_CNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [TS_W-1:0]             ts_cnt_q, ts_cnt_d;
  logic [NUM_CH-1:0]           pending_q, pending_d;
  logic [TS_W-1:0]             ts_cap_q [NUM_CH];
  logic [TS_W-1:0]             ts_cap_d [NUM_CH];
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [AER_CH_W+TS_W-1:0]    data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ovf_q, ovf_d;
  logic [NUM_CH-1:0]           drop_vec;

  logic                        gnt_valid;
  logic [IDX_W-1:0]            gnt_idx;

  aer_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (pending_q),
    .ptr       (rr_ptr_q),
    .en        (!fifo_full),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    ts_cnt_d  = ts_cnt_q + TS_W'(1);
    pending_d = pending_q;
    ts_cap_d  = ts_cap_q;
    rr_ptr_d  = rr_ptr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    drop_vec  = '0;

    if (gnt_valid) begin
      pending_d[gnt_idx] = 1'b0;
      data_d             = {AER_CH_W'(gnt_idx), ts_cap_q[gnt_idx]};
      valid_d            = 1'b1;
      rr_ptr_d           = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0
                                                           : gnt_idx + IDX_W'(1);
    end

    // The grant clear is applied first, so a spike on the channel being
    // granted re-arms it with a fresh timestamp instead of being dropped.
    for (int c = 0; c < NUM_CH; c++) begin
      if (spike_in[c]) begin
        if (pending_d[c]) begin
          drop_vec[c] = 1'b1;
        end else begin
          pending_d[c] = 1'b1;
          ts_cap_d[c]  = ts_cnt_q;
        end
      end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (|drop_vec)         ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      pending_q <= '0;
      ts_cap_q  <= '{default: '0};
      rr_ptr_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      pending_q <= pending_d;
      ts_cap_q  <= ts_cap_d;
      rr_ptr_q  <= rr_ptr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data      = data_q;
  assign aer_valid = valid_q;
  assign overflow  = ovf_q;

`ifdef AER_ENC_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] drops_now;

  always_comb begin
    drops_now  = 16'($countones(drop_vec));
    // Clearing restarts the count from this cycle's drops.
    drop_cnt_d = overflow_clr ? sat_add16(16'h0000, drops_now)
                              : sat_add16(drop_cnt_q, drops_now);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule : aer_encoder

// File: tb/tb_aer_encoder.sv
// ---------------------------------------------------------------------------
// tb_aer_encoder -- self-checking bench for aer_encoder.
//
// A behavioural model (per-channel pending flags and timestamps, a rotating
// start index) predicts every output each cycle; a compare process checks the
// DUT on the falling edge. Directed sequences pin the model with hand-derived
// literals; a randomized phase follows. A second, narrow-timestamp instance
// exercises the counter wrap within a short run.
// ---------------------------------------------------------------------------
module tb_aer_encoder;
  import aer_pkg::*;

  localparam int NC   = 16;
  localparam int TW   = 20;
  localparam int TW_S = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NC-1:0]         spike_in;
  logic                  fifo_full;
  logic                  overflow_clr;
  logic [AER_WORD_W-1:0] data;
  logic                  aer_valid;
  logic                  overflow;
`ifdef AER_ENC_DROP_CNT_EN
  logic [15:0]           drop_count;
  logic [15:0]           drop_count_w;
`endif

  logic [NC-1:0]         spike_w;
  logic                  fifo_w;
  logic [AER_CH_W+TW_S-1:0] data_w;
  logic                  valid_w;
  logic                  ovf_w;

  aer_encoder #(.NUM_CH(NC), .TS_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (spike_in),
    .fifo_full    (fifo_full),
    .overflow_clr (overflow_clr),
    .data         (data),
    .aer_valid    (aer_valid),
    .overflow     (overflow)
`ifdef AER_ENC_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  aer_encoder #(.NUM_CH(NC), .TS_W(TW_S)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .spike_in     (spike_w),
    .fifo_full    (fifo_w),
    .overflow_clr (overflow_clr),
    .data         (data_w),
    .aer_valid    (valid_w),
    .overflow     (ovf_w)
`ifdef AER_ENC_DROP_CNT_EN
    ,
    .drop_count   (drop_count_w)
`endif
  );

  // ---------------- counters / check helper ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [AER_WORD_W-1:0] exp_q[$];
  bit   m_pend [NC];
  int   m_tsc  [NC];
  int   m_ts, m_ptr;
  bit   model_ok = 1'b0;
  bit   e_valid, e_ovf;
  logic [AER_WORD_W-1:0] e_data, w_pop;
  int   e_dc, g, drops, base;

  always @(negedge clk) begin
    if (model_ok) begin
      check("valid", {31'd0, aer_valid}, {31'd0, e_valid});
      check("data", {8'd0, data}, {8'd0, e_data});
      check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
`ifdef AER_ENC_DROP_CNT_EN
      check("drop_count", {16'd0, drop_count}, e_dc);
`endif
      if (e_valid) begin
        w_pop = exp_q.pop_front();
        check("sb_word", {8'd0, data}, {8'd0, w_pop});
      end
    end

    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_pend[c] = 1'b0;
        m_tsc[c]  = 0;
      end
      m_ts = 0; m_ptr = 0;
      exp_q.delete();
      e_valid = 1'b0; e_data = '0; e_ovf = 1'b0; e_dc = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      g = -1;
      if (!fifo_full) begin
        for (int i = 0; i < NC; i++)
          if (g < 0 && m_pend[(m_ptr + i) % NC]) g = (m_ptr + i) % NC;
      end
      e_valid = (g >= 0);
      if (g >= 0) begin
        e_data = {4'(g), 20'(m_tsc[g])};
        exp_q.push_back(e_data);
        m_pend[g] = 1'b0;
        m_ptr = (g + 1) % NC;
      end
      drops = 0;
      for (int c = 0; c < NC; c++) begin
        if (spike_in[c]) begin
          if (m_pend[c]) drops++;
          else begin
            m_pend[c] = 1'b1;
            m_tsc[c]  = m_ts;
          end
        end
      end
      if (drops > 0)         e_ovf = 1'b1;
      else if (overflow_clr) e_ovf = 1'b0;
      base = overflow_clr ? 0 : e_dc;
      e_dc = (base + drops > 65535) ? 65535 : base + drops;
      m_ts = (m_ts + 1) % (1 << TW);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench in cycle 0 after reset, where the timestamp counter is 0.
  task automatic do_reset();
    rst = 1'b1; spike_in = '0; spike_w = '0; fifo_full = 1'b0; overflow_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  logic [AER_WORD_W-1:0] w;
  int t_s, t1;
  logic [3:0] chs [3];

  initial begin
    rst = 1'b1; spike_in = '0; spike_w = '0; fifo_w = 1'b0;
    fifo_full = 1'b0; overflow_clr = 1'b0;
    do_reset();
    check("rst_valid", {31'd0, aer_valid}, 32'd0);
    check("rst_data", {8'd0, data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single spike on channel 5 at timestamp 0x10.
    repeat (16) tick();
    spike_in = 16'h0020;
    tick();
    spike_in = '0;
    check("lat_pend_cycle", {31'd0, aer_valid}, 32'd0);
    tick();
    check("lat_valid", {31'd0, aer_valid}, 32'd1);
    check("lat_data", {8'd0, data}, 32'h0050_0010);

    // All channels at once: 16 back-to-back words, ascending, same timestamp.
    do_reset();
    spike_in = 16'hFFFF;
    tick();
    spike_in = '0;
    tick();
    for (int i = 0; i < NC; i++) begin
      w = {4'(i), 20'h0};
      check("burst_valid", {31'd0, aer_valid}, 32'd1);
      check("burst_data", {8'd0, data}, {8'd0, w});
      tick();
    end
    check("burst_end", {31'd0, aer_valid}, 32'd0);

    // Backpressure: three channels pending behind a full FIFO.
    fifo_full = 1'b1;
    spike_in  = 16'h1082;
    t_s = cyc;
    tick();
    spike_in = '0;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {31'd0, aer_valid}, 32'd0);
      tick();
    end
    fifo_full = 1'b0;
    tick();
    chs[0] = 4'd1; chs[1] = 4'd7; chs[2] = 4'd12;
    for (int i = 0; i < 3; i++) begin
      w = {chs[i], 20'(t_s)};
      check("bp_valid", {31'd0, aer_valid}, 32'd1);
      check("bp_data", {8'd0, data}, {8'd0, w});
      tick();
    end
    check("bp_end", {31'd0, aer_valid}, 32'd0);

    // Double spike on channel 2 under backpressure: second one is dropped.
    fifo_full = 1'b1;
    spike_in  = 16'h0004;
    t1 = cyc;
    tick();
    spike_in = '0;
    tick();
    spike_in = 16'h0004;
    tick();
    spike_in = '0;
    check("drop_ovf", {31'd0, overflow}, 32'd1);
`ifdef AER_ENC_DROP_CNT_EN
    check("drop_cnt1", {16'd0, drop_count}, 32'd1);
`endif
    fifo_full = 1'b0;
    tick();
    w = {4'd2, 20'(t1)};
    check("drop_word_valid", {31'd0, aer_valid}, 32'd1);
    check("drop_word_data", {8'd0, data}, {8'd0, w});
    tick();
    check("drop_single", {31'd0, aer_valid}, 32'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Reset with four channels pending and overflow set; spikes during reset.
    fifo_full = 1'b1;
    spike_in  = 16'h4209;
    tick();
    spike_in = 16'h0008;
    tick();
    spike_in = '0;
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, aer_valid}, 32'd0);
    check("mid_rst_data", {8'd0, data}, 32'd0);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    spike_in = 16'hFFFF;
    tick();
    spike_in = '0; rst = 1'b0; fifo_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_idle", {31'd0, aer_valid}, 32'd0);
      tick();
    end

    // Timestamp wrap on the narrow instance (6-bit counter wraps at 63).
    do_reset();
    repeat (63) tick();
    spike_w = 16'h0001;
    tick();
    spike_w = 16'h0002;
    tick();
    spike_w = '0;
    check("wrap_valid0", {31'd0, valid_w}, 32'd1);
    check("wrap_max", {22'd0, data_w}, 32'h03F);
    tick();
    check("wrap_valid1", {31'd0, valid_w}, 32'd1);
    check("wrap_zero", {22'd0, data_w}, 32'h040);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) spike_in[c] = ($urandom_range(0, 7) == 0);
      fifo_full    = ($urandom_range(0, 3) == 0);
      overflow_clr = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      tick();
    end
    spike_in = '0; fifo_full = 1'b0; overflow_clr = 1'b0; rst = 1'b0;
    repeat (40) tick();
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_aer_encoder

// File: doc/aer_encoder.md
AER_ENCODER -- requirements
Module: aer_encoder

Interface
REQ-001 Parameter NUM_CH, default 16, number of spike input channels; the channel ID is 4 bits wide.
REQ-002 Parameter TS_W, default 20, width of the timestamp counter and of the timestamp field.
REQ-003 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port spike_in, input, NUM_CH, per-channel spike pulses; each high cycle is one spike.
REQ-006 Port fifo_full, input, 1, backpressure from the downstream aer_pipeline.
REQ-007 Port overflow_clr, input, 1, clears overflow.
REQ-008 Port data, output, 24, AER word; bits [23:20] are the channel ID, bits [19:0] are the timestamp.
REQ-009 Port aer_valid, output, 1, data is valid this cycle; one word per high cycle.
REQ-010 Port overflow, output, 1, sticky flag indicating a spike was dropped.

Function
REQ-011 The free-running counter ts_cnt SHALL increment every cycle and wrap from 2^TS_W-1 to 0.
REQ-012 A spike_in[c] high in cycle N SHALL set pending[c] and capture ts_cap[c]=ts_cnt(N) at the next edge.
REQ-013 A spike on a channel whose pending bit is already set and not granted in the same cycle SHALL be dropped, keep the original ts_cap, and set overflow.
REQ-014 A spike on the channel granted in the same cycle SHALL re-set pending with the new timestamp; the set wins over the clear.
REQ-015 Each cycle with fifo_full=0 and any pending bit set, the encoder SHALL grant exactly one channel, chosen round-robin.
  - Search starts at rr_ptr.
  - After a grant, rr_ptr = grant+1 mod NUM_CH.
REQ-016 The grant SHALL clear pending[grant] and register the word {grant[3:0], ts_cap[grant]} onto data with aer_valid=1 at the next edge.
REQ-017 With fifo_full=1 or no pending bits, there SHALL be no grant, aer_valid=0 next cycle, and pending/rr_ptr held.
REQ-018 The data output SHALL hold its last value when aer_valid=0.
REQ-019 Latency SHALL be fixed for an idle encoder.
  - Spike in cycle N gives aer_valid=1 in cycle N+2.
  - Sustained throughput is one word per cycle.
REQ-020 fifo_full SHALL be sampled combinationally in the grant cycle; no word is emitted while it is high.
REQ-021 overflow_clr SHALL clear overflow; a drop in the same cycle takes priority, so overflow stays set.
REQ-022 Simultaneous spikes on k channels SHALL each be emitted exactly once over k grant cycles, each with its own capture timestamp.

Reset
REQ-023 rst high at a clock edge SHALL reset the encoder as follows:
  - ts_cnt=0, pending=0, ts_cap=0, rr_ptr=0.
  - data=24'h000000, aer_valid=0, overflow=0.
REQ-024 Reset mid-operation SHALL discard all pending spikes without emitting them.
REQ-025 Spikes asserted while rst is high SHALL be ignored.

Configuration
REQ-026 Macro AER_ENC_DROP_CNT_EN defined SHALL add the output drop_count[15:0], which behaves as follows:
  - Increments once per dropped spike and saturates at 16'hFFFF.
  - Counts multiple drops in one cycle as that many increments, still saturating.
  - Is cleared by rst and by overflow_clr.
REQ-027 Macro AER_ENC_DROP_CNT_EN undefined SHALL remove the port and counter; all other behaviour is identical.

Structure
REQ-028 Package aer_pkg SHALL hold AER_CH_W=4, AER_TS_W=20, AER_WORD_W=24, and the typedef aer_word_t (packed {ch, ts}).
REQ-029 Round-robin selection SHALL be the sub-module aer_rr_arbiter, defined as follows:
  - Inputs: req[NUM_CH], ptr, en.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational.

Verification
REQ-030 After reset, spike_in[5] pulsed when ts_cnt=0x00010 SHALL give aer_valid one cycle later than the pending set, with data=24'h500010.
REQ-031 spike_in=16'hFFFF for one cycle with rr_ptr=0 SHALL emit 16 consecutive words, channels 0..15, all carrying the same timestamp.
REQ-032 fifo_full held high for 20 cycles with 3 channels pending SHALL give aer_valid=0 throughout; after release, 3 words follow on consecutive cycles.
REQ-033 Channel 2 spiked twice while fifo_full=1 SHALL emit one word with the first timestamp and set overflow=1; with AER_ENC_DROP_CNT_EN, drop_count=1.
REQ-034 A spike at ts_cnt=0xFFFFF SHALL be stamped 0xFFFFF, and the next cycle's spike SHALL be stamped 0x00000.
REQ-035 rst asserted with 4 channels pending SHALL emit no words, and all outputs SHALL be at their reset values the next cycle.
